// File: rtl/sms4_pkg.sv
// SMS4 key-schedule constants: FK, CK generator, S-box, FSM states.
// Shared by the key scheduler and its round-function sub-block.
package sms4_pkg;

  localparam int unsigned NROUNDS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sms4_state_e;

  localparam logic [31:0] FK [4] = '{
    32'hA3B1BAC6, 32'h56AA3350,
    32'h677D9197, 32'hB27022DC
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,
    8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,
    8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,
    8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,
    8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,
    8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,
    8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,
    8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,
    8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,
    8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,
    8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,
    8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,
    8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,
    8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,
    8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,
    8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,
    8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  // CK[i] byte j (j=0 is the MSB) = ((4i+j)*7) mod 256
  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [31:0] v;
    int          b;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      b = (4 * int'(i) + j) * 7;
      v[31-8*j -: 8] = 8'(b);
    end
    return v;
  endfunction

  function automatic logic [31:0] rotl32(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sms4_key_sched_if.sv
// Control, round-key stream and key-store read bundle.
// slave: key scheduler side; master: controller / round core side.
interface sms4_key_sched_if;

  logic         start;
  logic [127:0] key_in;
  logic         zeroize;
  logic         busy;
  logic         keys_valid;
  logic [31:0]  rk_out;
  logic [4:0]   rk_out_idx;
  logic         rk_out_valid;
  logic         rd_en;
  logic [4:0]   rd_idx;
  logic [31:0]  rd_rk;
  logic         rd_valid;

  modport slave (
    input  start, key_in, zeroize,
    input  rd_en, rd_idx,
    output busy, keys_valid,
    output rk_out, rk_out_idx, rk_out_valid,
    output rd_rk, rd_valid
  );

  modport master (
    output start, key_in, zeroize,
    output rd_en, rd_idx,
    input  busy, keys_valid,
    input  rk_out, rk_out_idx, rk_out_valid,
    input  rd_rk, rd_valid
  );

endinterface

// File: rtl/sms4_key_tprime.sv
// Key-schedule T' = L'(tau(i_t)): four S-box lookups, B^rotl13^rotl23.
// Ports: i_t (32b word in), o_l (32b transformed word out). Combinational.
module sms4_key_tprime
  import sms4_pkg::*;
(
  input  logic [31:0] i_t,
  output logic [31:0] o_l
);

  logic [31:0] w_b;

  assign w_b = {SBOX[i_t[31:24]], SBOX[i_t[23:16]],
                SBOX[i_t[15:8]],  SBOX[i_t[7:0]]};

  assign o_l = w_b ^ rotl32(w_b, 13) ^ rotl32(w_b, 23);

endmodule

// File: rtl/sms4_key_sched.sv
// SMS4 key expansion: one round key per clock into a 32-entry store.
// Ports: clk, rst (sync, active-high), bus (sms4_key_sched_if.slave).
module sms4_key_sched #(
  parameter int unsigned BWIDTH  = 32,
  parameter int unsigned NROUNDS = 32
) (
  input  logic            clk,
  input  logic            rst,
  sms4_key_sched_if.slave bus
);
  import sms4_pkg::*;

  sms4_state_e       r_state;
  sms4_state_e       w_state_nxt;
  logic [4:0]        r_cnt;
  logic [BWIDTH-1:0] r_k [4];
  logic [BWIDTH-1:0] r_store [NROUNDS];
  logic              r_busy;
  logic              r_kv;
  logic [BWIDTH-1:0] r_rk_out;
  logic [4:0]        r_rk_out_idx;
  logic              r_rk_out_valid;
  logic [BWIDTH-1:0] r_rd_rk;
  logic              r_rd_valid;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [31:0]       w_t;
  logic [31:0]       w_l;
  logic [BWIDTH-1:0] w_rk;

  assign w_last = (r_cnt == 5'(NROUNDS - 1));
  assign w_t    = r_k[1] ^ r_k[2] ^ r_k[3] ^ ck(r_cnt);
  assign w_rk   = r_k[0] ^ w_l;

  sms4_key_tprime u_tprime (
    .i_t (w_t),
    .o_l (w_l)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    if (bus.zeroize) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          w_step = 1'b1;
          if (w_last) w_state_nxt = DONE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_kv           <= 1'b0;
      r_rk_out       <= '0;
      r_rk_out_idx   <= '0;
      r_rk_out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) r_k[i] <= '0;
      for (int i = 0; i < int'(NROUNDS); i++) r_store[i] <= '0;
    end else if (bus.zeroize) begin
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_kv           <= 1'b0;
      r_rk_out       <= '0;
      r_rk_out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) r_k[i] <= '0;
      for (int i = 0; i < int'(NROUNDS); i++) r_store[i] <= '0;
    end else begin
      r_busy         <= (w_state_nxt == RUN);
      r_kv           <= (w_state_nxt == DONE);
      r_rk_out_valid <= w_step;
      if (w_load) begin
        r_k[0] <= bus.key_in[127:96] ^ FK[0];
        r_k[1] <= bus.key_in[95:64]  ^ FK[1];
        r_k[2] <= bus.key_in[63:32]  ^ FK[2];
        r_k[3] <= bus.key_in[31:0]   ^ FK[3];
        r_cnt  <= '0;
      end else if (w_step) begin
        r_store[r_cnt] <= w_rk;
        r_rk_out       <= w_rk;
        r_rk_out_idx   <= r_cnt;
        r_k[0]         <= r_k[1];
        r_k[1]         <= r_k[2];
        r_k[2]         <= r_k[3];
        r_k[3]         <= w_rk;
        // final increment wraps to 0; state has moved to DONE
        r_cnt          <= r_cnt + 5'd1;
      end
    end
  end

  // Read port samples the pre-edge store, so a same-edge write is not seen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_rk    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.zeroize)    r_rd_rk <= '0;
      else if (bus.rd_en) r_rd_rk <= r_store[bus.rd_idx];
    end
  end

  assign bus.busy         = r_busy;
  assign bus.keys_valid   = r_kv;
  assign bus.rk_out       = r_rk_out;
  assign bus.rk_out_idx   = r_rk_out_idx;
  assign bus.rk_out_valid = r_rk_out_valid;
  assign bus.rd_rk        = r_rd_rk;
  assign bus.rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_sms4_key_sched.sv
// Directed bench for sms4_key_sched using the standard SMS4 key.
// rk0/rk31 of key 0123..3210 are F12186F9 / 9124A012.
module tb_sms4_key_sched;

  localparam logic [127:0] KSTD = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [31:0]  RK0  = 32'hF12186F9;
  localparam logic [31:0]  RK31 = 32'h9124A012;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  sms4_key_sched_if bus ();

  sms4_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_kv"}, 32'(bus.keys_valid), 32'd0);
    chk({tag, "_rkv"}, 32'(bus.rk_out_valid), 32'd0);
    chk({tag, "_rk"}, bus.rk_out, 32'd0);
  endtask

  // kind: 0 none, 1 start mid-run, 2 zeroize+start, 3 rst
  // rdm : 0 none, 1 same-edge read/write, 2 stale read of idx31
  task automatic expand(
    input logic [127:0] key,
    input bit           known,
    input int           at,
    input int           kind,
    input int           rdm
  );
    bus.key_in = key;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    chk("busy_on", 32'(bus.busy), 32'd1);
    chk("kv_drop", 32'(bus.keys_valid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (i == at) begin
        if (kind == 1) bus.start = 1'b1;
        if (kind == 2) begin
          bus.zeroize = 1'b1;
          bus.start   = 1'b1;
        end
        if (kind == 3) rst = 1'b1;
      end
      if (rdm == 1 && (i == 5 || i == 31)) begin
        bus.rd_en  = 1'b1;
        bus.rd_idx = 5'(i);
      end
      if (rdm == 2 && i == 0) begin
        bus.rd_en  = 1'b1;
        bus.rd_idx = 5'd31;
      end
      tick();
      bus.start = 1'b0;
      if (i == at && kind == 2) begin
        bus.zeroize = 1'b0;
        chk_idle("zero");
        return;
      end
      if (i == at && kind == 3) begin
        rst = 1'b0;
        chk_idle("rst");
        chk("rst_idx", 32'(bus.rk_out_idx), 32'd0);
        chk("rst_rd", bus.rd_rk, 32'd0);
        chk("rst_rdv", 32'(bus.rd_valid), 32'd0);
        return;
      end
      chk("rk_valid", 32'(bus.rk_out_valid), 32'd1);
      chk("rk_idx", 32'(bus.rk_out_idx), 32'(i));
      if (known && i == 0)  chk("rk0", bus.rk_out, RK0);
      if (known && i == 31) chk("rk31", bus.rk_out, RK31);
      if (i == 30) chk("kv_early", 32'(bus.keys_valid), 32'd0);
      if (i == 31) chk("kv_rise", 32'(bus.keys_valid), 32'd1);
      if (rdm == 1 && (i == 5 || i == 31)) begin
        chk("rw_old", bus.rd_rk, 32'd0);
        chk("rw_rdv", 32'(bus.rd_valid), 32'd1);
      end
      if (rdm == 1 && i == 6) begin
        chk("rw_new", 32'(bus.rd_rk != 32'd0), 32'd1);
        bus.rd_en = 1'b0;
      end
      if (rdm == 2 && i == 0) begin
        chk("stale", bus.rd_rk, RK31);
        bus.rd_en = 1'b0;
      end
    end
    tick();
    chk("rkv_off", 32'(bus.rk_out_valid), 32'd0);
    chk("busy_off", 32'(bus.busy), 32'd0);
    if (known) chk("rk_hold", bus.rk_out, RK31);
    if (rdm == 1) begin
      chk("rw_new31", bus.rd_rk, RK31);
      bus.rd_en = 1'b0;
    end
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.key_in  = '0;
    bus.zeroize = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_idx  = '0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_rd", bus.rd_rk, 32'd0);
    chk("reset_rdv", 32'(bus.rd_valid), 32'd0);
    rst = 1'b0;
    tick();

    // standard key with same-edge read/write probes
    expand(KSTD, 1'b1, -1, 0, 1);

    // read back first and last key
    bus.rd_en  = 1'b1;
    bus.rd_idx = 5'd0;
    tick();
    chk("rd0", bus.rd_rk, RK0);
    chk("rd0_v", 32'(bus.rd_valid), 32'd1);
    bus.rd_idx = 5'd31;
    tick();
    chk("rd31", bus.rd_rk, RK31);
    bus.rd_en = 1'b0;
    tick();
    chk("rd_hold", bus.rd_rk, RK31);
    chk("rd_v_off", 32'(bus.rd_valid), 32'd0);

    // start during RUN is ignored
    expand(KSTD, 1'b1, 10, 1, 0);
    chk("kv_done", 32'(bus.keys_valid), 32'd1);
    // re-key from DONE with key 0, store stale at first
    expand('0, 1'b0, -1, 0, 2);

    // zeroize beats start at round 15
    expand(KSTD, 1'b1, 15, 2, 0);
    bus.rd_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      bus.rd_idx = 5'(k);
      tick();
      chk("zero_rd", bus.rd_rk, 32'd0);
    end
    bus.rd_en = 1'b0;
    tick();

    // rst at round 20, then full rerun
    expand(KSTD, 1'b1, 20, 3, 0);
    tick();
    expand(KSTD, 1'b1, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sms4_key_sched.md
Name: sms4_key_sched

Overview:
Sequential SMS4 key-expansion controller.
- Accepts a 128-bit master key MK.
- Iterates the key schedule one round per clock: tau S-box substitution, then L'(B) = B ^ rotl13(B) ^ rotl23(B).
- Produces round keys rk0..rk31, streams each one out as it is computed, and stores all 32 in an internal key store.
- The encrypt/decrypt round core reads the key store by index; decrypt reads indices 31..0.

Parameters:
BWIDTH, 32, word width; fixed by the SMS4 algorithm, only 32 is supported.
NROUNDS, 32, number of round keys; fixed, only 32 is supported.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to expand key_in; sampled only in IDLE or DONE.
key_in  in  128  master key MK; MK0 = key_in[127:96] ... MK3 = key_in[31:0].
zeroize  in  1  clears all key material; highest priority after rst.
busy  out  1  expansion in progress.
keys_valid  out  1  all 32 keys in the store are valid for the current key.
rk_out  out  32  round key being written this cycle.
rk_out_idx  out  5  index of rk_out.
rk_out_valid  out  1  rk_out / rk_out_idx valid.
rd_en  in  1  key-store read request.
rd_idx  in  5  key-store read address.
rd_rk  out  32  registered read data.
rd_valid  out  1  rd_rk valid; rd_en delayed by one cycle.

Behaviour:
- Reset (rst = 1 at a clock edge), all of the following take effect at that edge:
  - state = IDLE; cnt = 0; K0..K3 = 0.
  - Key store cleared to 0.
  - All outputs 0.
  - rst mid-expansion aborts the expansion.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start = 1 and zeroize = 0:
  - K0..K3 <= MKi ^ FKi.
  - cnt <= 0; state <= RUN; busy <= 1; keys_valid <= 0.
- RUN, each cycle:
  - T = K1 ^ K2 ^ K3 ^ CK[cnt].
  - rk = K0 ^ L'(tau(T)).
  - store[cnt] <= rk; rk_out <= rk; rk_out_idx <= cnt; rk_out_valid <= 1.
  - Shift window: K0 <= K1, K1 <= K2, K2 <= K3, K3 <= rk.
  - cnt <= cnt + 1.
- RUN with cnt = 31: after that write, state <= DONE; busy <= 0; keys_valid <= 1.
- Latency:
  - Edge E samples start.
  - rk_i is registered at edge E+1+i, i.e. rk_out_valid is high for 32 consecutive cycles.
  - keys_valid rises at edge E+32.
- Outside RUN: rk_out_valid = 0; rk_out and rk_out_idx hold their last values.
- start while in RUN is ignored; there is no restart.
- start in DONE re-keys: keys_valid drops at the next edge.
- zeroize = 1 at any edge, in any state:
  - state <= IDLE; store, K0..K3 and rk_out cleared; keys_valid <= 0; busy <= 0.
  - Wins over a simultaneous start.
- CK[i] byte j = ((4i + j) * 7) mod 256. Generated combinationally from cnt, or taken from the package table.
- FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
- Read port:
  - rd_rk <= store[rd_idx] when rd_en; 1-cycle latency.
  - Reads are allowed in any state and return current store contents, which may be stale while busy.
  - Read and write of the same index in the same cycle returns the old value.
- rd_rk holds its value when rd_en = 0.
- cnt is 5 bits; wraps only on the final round, and that wrap is masked by the state change.

Decomposition:
- Package sms4_pkg:
  - FK[0:3].
  - CK[0:31] table, or the CK generator function.
  - SBOX[0:255] table.
  - State enum {IDLE, RUN, DONE}.
  - NROUNDS.
- Sub-module sms4_key_tprime (combinational):
  - Four S-box lookups, then B ^ rotl13(B) ^ rotl23(B).
  - Reuses the existing shift blocks for the rotates.
  - Instantiated once inside sms4_key_sched.

Test Plan:
1. Standard vector: key_in = 0123456789ABCDEFFEDCBA9876543210, pulse start → rk_out_valid high for 32 cycles; rk_out idx0 = F12186F9, idx31 = 9124A012; keys_valid rises exactly 32 edges after start.
2. Read back: after case 1, rd_en with rd_idx = 0, then 31 → rd_rk = F12186F9 / 9124A012 one cycle later with rd_valid = 1; read while keys_valid = 0 returns the stored value.
3. start asserted again at round 10 → ignored; sequence completes unchanged; then start in DONE with key 0 → keys_valid falls next edge; new 32-key sequence follows.
4. zeroize asserted at round 15 together with start → IDLE next edge; busy = 0, keys_valid = 0; all 32 reads return 00000000.
5. rst asserted mid-RUN (round 20) → next edge: all outputs 0, state IDLE; subsequent start on the standard key reproduces case 1 exactly.
6. Same-cycle read/write: rd_en, rd_idx = 5 on the edge that writes rk5 → rd_rk = previous store value (0 after reset); a read the next cycle returns the new rk5.
